// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
//
// Sequences MEM-stage loads and stores onto an external 16-bit asynchronous
// SRAM. Each 32-bit word moves as two half-word phases (low half, then high
// half). Each phase holds the bus for WAIT_CYCLES cycles. While an access is
// in flight, `ready` is low so the top level can freeze the pipeline.
//
// Parameters
//   WAIT_CYCLES  cycles each half-word phase is held on the SRAM bus (>= 1)
//   BASE_ADDR    byte address that maps to SRAM word 0
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-low
//   wr_en        store request
//   rd_en        load request (a store wins if both are asserted)
//   address      byte address of the access
//   write_data   store data
//   read_data    load result; held until a later read overwrites it
//   ready        1 = pipeline may advance, 0 = freeze
//   sram_addr    SRAM half-word address
//   sram_we_n    SRAM write strobe, active-low
//   sram_dq_out  data driven toward the SRAM
//   sram_dq_oe   1 = top level drives sram_dq_out onto the bus
//   sram_dq_in   data read back from the SRAM bus
// ---------------------------------------------------------------------------
module sram_controller #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic        sram_we_n,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in
);

    localparam int             CNT_W    = $clog2(WAIT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [16:0]      r_widx;   // latched SRAM word index of the access
    logic [31:0]      r_wdata;  // latched store data

    logic [31:0] w_off;
    logic [16:0] w_idx;
    logic        w_last;
    logic        w_unused_bits;

    // Addresses below BASE_ADDR wrap modulo 2^32; only 17 word-index bits
    // reach the SRAM.
    assign w_off         = address - BASE_ADDR;
    assign w_idx         = w_off[18:2];
    assign w_unused_bits = ^{w_off[31:19], w_off[1:0]};

    assign w_last = (r_cnt == CNT_LAST);

    always_comb begin
        ready = ((r_state == S_IDLE) && !(rd_en || wr_en)) || (r_state == S_DONE);
    end

    // Bus outputs are registered. They are loaded on the edge that enters
    // each phase, so they stay aligned with the state for the whole phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_widx      <= '0;
            r_wdata     <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
            sram_dq_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (wr_en) begin
                        r_widx      <= w_idx;
                        r_wdata     <= write_data;
                        sram_addr   <= {w_idx, 1'b0};
                        sram_we_n   <= 1'b0;
                        sram_dq_oe  <= 1'b1;
                        sram_dq_out <= write_data[15:0];
                        r_state     <= S_WR_LO;
                    end else if (rd_en) begin
                        r_widx    <= w_idx;
                        sram_addr <= {w_idx, 1'b0};
                        r_state   <= S_RD_LO;
                    end
                end

                S_RD_LO: begin
                    if (w_last) begin
                        read_data[15:0] <= sram_dq_in;
                        r_cnt           <= '0;
                        sram_addr       <= {r_widx, 1'b1};
                        r_state         <= S_RD_HI;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_RD_HI: begin
                    if (w_last) begin
                        read_data[31:16] <= sram_dq_in;
                        r_cnt            <= '0;
                        sram_addr        <= {r_widx, 1'b0};
                        r_state          <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_WR_LO: begin
                    if (w_last) begin
                        r_cnt       <= '0;
                        sram_addr   <= {r_widx, 1'b1};
                        sram_dq_out <= r_wdata[31:16];
                        r_state     <= S_WR_HI;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_WR_HI: begin
                    if (w_last) begin
                        r_cnt      <= '0;
                        sram_addr  <= {r_widx, 1'b0};
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_cnt      <= '0;
                    sram_we_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_controller
//
// Three controller instances with WAIT_CYCLES = 2, 3 and 1. Each instance
// sits behind its own behavioural SRAM model. Inputs change and outputs are
// sampled on the falling clock edge. "Cycle 0" is the IDLE cycle in which a
// request is first presented.
// ---------------------------------------------------------------------------
module tb_sram_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- W = 2 instance ----------------
    logic        rst2, wr2, rd2, rdy2, we2, oe2;
    logic [31:0] a2, wd2, rdat2;
    logic [17:0] sa2;
    logic [15:0] dqo2, dqi2;
    logic [15:0] mem2 [0:262143];

    sram_controller #(.WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) u2 (
        .clk(clk), .rst(rst2), .wr_en(wr2), .rd_en(rd2), .address(a2),
        .write_data(wd2), .read_data(rdat2), .ready(rdy2), .sram_addr(sa2),
        .sram_we_n(we2), .sram_dq_out(dqo2), .sram_dq_oe(oe2), .sram_dq_in(dqi2)
    );
    always @(posedge clk) if (!we2 && oe2) mem2[sa2] <= dqo2;
    assign dqi2 = mem2[sa2];

    // ---------------- W = 3 instance ----------------
    logic        rst3, wr3, rd3, rdy3, we3, oe3;
    logic [31:0] a3, wd3, rdat3;
    logic [17:0] sa3;
    logic [15:0] dqo3, dqi3;
    logic [15:0] mem3 [0:262143];

    sram_controller #(.WAIT_CYCLES(3), .BASE_ADDR(32'd1024)) u3 (
        .clk(clk), .rst(rst3), .wr_en(wr3), .rd_en(rd3), .address(a3),
        .write_data(wd3), .read_data(rdat3), .ready(rdy3), .sram_addr(sa3),
        .sram_we_n(we3), .sram_dq_out(dqo3), .sram_dq_oe(oe3), .sram_dq_in(dqi3)
    );
    always @(posedge clk) if (!we3 && oe3) mem3[sa3] <= dqo3;
    assign dqi3 = mem3[sa3];

    // ---------------- W = 1 instance ----------------
    logic        rst1, wr1, rd1, rdy1, we1, oe1;
    logic [31:0] a1, wd1, rdat1;
    logic [17:0] sa1;
    logic [15:0] dqo1, dqi1;
    logic [15:0] mem1 [0:262143];

    sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) u1 (
        .clk(clk), .rst(rst1), .wr_en(wr1), .rd_en(rd1), .address(a1),
        .write_data(wd1), .read_data(rdat1), .ready(rdy1), .sram_addr(sa1),
        .sram_we_n(we1), .sram_dq_out(dqo1), .sram_dq_oe(oe1), .sram_dq_in(dqi1)
    );
    always @(posedge clk) if (!we1 && oe1) mem1[sa1] <= dqo1;
    assign dqi1 = mem1[sa1];

    // -----------------------------------------------------------------------
    task automatic test_reset;
        rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
        wr1 = 1'b0; rd1 = 1'b0; a1 = '0; wd1 = '0;
        wr2 = 1'b0; rd2 = 1'b0; a2 = '0; wd2 = '0;
        wr3 = 1'b0; rd3 = 1'b0; a3 = '0; wd3 = '0;
        repeat (3) @(negedge clk);
        n_vec++; if (rdat2 !== 32'h0) begin n_err++; $display("FAIL reset_read_data got=%h exp=%h", rdat2, 32'h0); end
        n_vec++; if (we2 !== 1'b1) begin n_err++; $display("FAIL reset_we_n got=%b exp=1", we2); end
        n_vec++; if (oe2 !== 1'b0) begin n_err++; $display("FAIL reset_dq_oe got=%b exp=0", oe2); end
        n_vec++; if (rdy2 !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", rdy2); end
        n_vec++; if (sa2 !== 18'h0) begin n_err++; $display("FAIL reset_sram_addr got=%h exp=0", sa2); end
        n_vec++; if (dqo2 !== 16'h0) begin n_err++; $display("FAIL reset_dq_out got=%h exp=0", dqo2); end
        n_vec++; if ({rdy3, we3, oe3, sa3, rdat3} !== {1'b1, 1'b1, 1'b0, 18'h0, 32'h0}) begin
            n_err++; $display("FAIL reset_w3 got rdy/we_n/oe/addr/rd=%b/%b/%b/%h/%h exp=1/1/0/0/0", rdy3, we3, oe3, sa3, rdat3);
        end
        n_vec++; if ({rdy1, we1, oe1, sa1, rdat1} !== {1'b1, 1'b1, 1'b0, 18'h0, 32'h0}) begin
            n_err++; $display("FAIL reset_w1 got rdy/we_n/oe/addr/rd=%b/%b/%b/%h/%h exp=1/1/0/0/0", rdy1, we1, oe1, sa1, rdat1);
        end
        rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_write_then_read;
        logic        er  [0:4];
        logic        ewe [0:4];
        logic        eoe [0:4];
        logic [17:0] ea  [0:4];
        logic [15:0] edq [0:4];
        er  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ewe = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        eoe = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ea  = '{18'd2, 18'd2, 18'd3, 18'd3, 18'd2};
        edq = '{16'hBEEF, 16'hBEEF, 16'hDEAD, 16'hDEAD, 16'h0000};

        @(negedge clk);
        wr2 = 1'b1; a2 = 32'd1028; wd2 = 32'hDEADBEEF;
        #1;
        n_vec++; if (rdy2 !== 1'b0) begin n_err++; $display("FAIL wr_cyc0_ready got=%b exp=0", rdy2); end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_vec++;
            if ({rdy2, we2, oe2, sa2} !== {er[c-1], ewe[c-1], eoe[c-1], ea[c-1]}) begin
                n_err++;
                $display("FAIL wr_seq cyc=%0d got rdy/we_n/oe/addr=%b/%b/%b/%h exp=%b/%b/%b/%h",
                         c, rdy2, we2, oe2, sa2, er[c-1], ewe[c-1], eoe[c-1], ea[c-1]);
            end
            if (eoe[c-1]) begin
                n_vec++;
                if (dqo2 !== edq[c-1]) begin n_err++; $display("FAIL wr_dq cyc=%0d got=%h exp=%h", c, dqo2, edq[c-1]); end
            end
        end
        wr2 = 1'b0;

        @(negedge clk);
        n_vec++; if (rdy2 !== 1'b1) begin n_err++; $display("FAIL idle_ready got=%b exp=1", rdy2); end
        rd2 = 1'b1; a2 = 32'd1028;
        #1;
        n_vec++; if (rdy2 !== 1'b0) begin n_err++; $display("FAIL rd_cyc0_ready got=%b exp=0", rdy2); end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_vec++;
            if ({rdy2, we2, oe2, sa2} !== {er[c-1], 1'b1, 1'b0, ea[c-1]}) begin
                n_err++;
                $display("FAIL rd_seq cyc=%0d got rdy/we_n/oe/addr=%b/%b/%b/%h exp=%b/1/0/%h",
                         c, rdy2, we2, oe2, sa2, er[c-1], ea[c-1]);
            end
            if (c == 3) begin
                n_vec++;
                if (rdat2 !== 32'h0000BEEF) begin n_err++; $display("FAIL rd_low_half got=%h exp=%h", rdat2, 32'h0000BEEF); end
            end
            if (c == 5) begin
                n_vec++;
                if (rdat2 !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_word got=%h exp=%h", rdat2, 32'hDEADBEEF); end
            end
        end
        rd2 = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_simultaneous;
        logic        er  [0:4];
        logic        ewe [0:4];
        logic [17:0] ea  [0:4];
        logic [15:0] edq [0:4];
        er  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ewe = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ea  = '{18'd4, 18'd4, 18'd5, 18'd5, 18'd4};
        edq = '{16'hF00D, 16'hF00D, 16'h0BAD, 16'h0BAD, 16'h0000};

        @(negedge clk);
        wr2 = 1'b1; rd2 = 1'b1; a2 = 32'd1032; wd2 = 32'h0BADF00D;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_vec++;
            if ({rdy2, we2, oe2, sa2} !== {er[c-1], ewe[c-1], ~ewe[c-1], ea[c-1]}) begin
                n_err++;
                $display("FAIL both_seq cyc=%0d got rdy/we_n/oe/addr=%b/%b/%b/%h exp=%b/%b/%b/%h",
                         c, rdy2, we2, oe2, sa2, er[c-1], ewe[c-1], ~ewe[c-1], ea[c-1]);
            end
            if (c <= 4) begin
                n_vec++;
                if (dqo2 !== edq[c-1]) begin n_err++; $display("FAIL both_dq cyc=%0d got=%h exp=%h", c, dqo2, edq[c-1]); end
            end
        end
        n_vec++; if (rdat2 !== 32'hDEADBEEF) begin n_err++; $display("FAIL both_read_data got=%h exp=%h", rdat2, 32'hDEADBEEF); end
        wr2 = 1'b0; rd2 = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_back_to_back;
        logic        er [0:10];
        logic [17:0] ea [0:10];
        er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ea = '{18'd0, 18'd0, 18'd1, 18'd1, 18'd0, 18'd0, 18'd4, 18'd4, 18'd5, 18'd5, 18'd4};

        // Seed word 0 through the controller (fixed 2W+1 cycle store).
        @(negedge clk);
        wr2 = 1'b1; a2 = 32'd1024; wd2 = 32'h12345678;
        repeat (5) @(negedge clk);
        wr2 = 1'b0;

        @(negedge clk);
        rd2 = 1'b1; a2 = 32'd1024;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            n_vec++;
            if ({rdy2, sa2} !== {er[c-1], ea[c-1]}) begin
                n_err++;
                $display("FAIL b2b cyc=%0d got rdy/addr=%b/%h exp=%b/%h", c, rdy2, sa2, er[c-1], ea[c-1]);
            end
            if (c == 5) begin
                n_vec++;
                if (rdat2 !== 32'h12345678) begin n_err++; $display("FAIL b2b_first got=%h exp=%h", rdat2, 32'h12345678); end
                a2 = 32'd1032;
            end
            if (c == 11) begin
                n_vec++;
                if (rdat2 !== 32'h0BADF00D) begin n_err++; $display("FAIL b2b_second got=%h exp=%h", rdat2, 32'h0BADF00D); end
            end
        end
        rd2 = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_mid_rd_hi;
        logic [17:0] ea [0:4];
        ea = '{18'd8, 18'd8, 18'd8, 18'd9, 18'd9};

        // Store 0x12345678 at word 4 (byte 1040); W=3 store takes 7 cycles.
        @(negedge clk);
        wr3 = 1'b1; a3 = 32'd1040; wd3 = 32'h12345678;
        repeat (7) @(negedge clk);
        wr3 = 1'b0;

        @(negedge clk);
        rd3 = 1'b1; a3 = 32'd1040;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_vec++;
            if ({rdy3, sa3} !== {1'b0, ea[c-1]}) begin
                n_err++;
                $display("FAIL rst_rd cyc=%0d got rdy/addr=%b/%h exp=0/%h", c, rdy3, sa3, ea[c-1]);
            end
        end
        // Second cycle of the high phase: low half already captured.
        n_vec++; if (rdat3 !== 32'h00005678) begin n_err++; $display("FAIL rst_rd_low got=%h exp=%h", rdat3, 32'h00005678); end
        rst3 = 1'b0;
        #1;
        n_vec++; if ({rdat3, sa3} !== {32'h0, 18'h0}) begin
            n_err++; $display("FAIL rst_async got rd/addr=%h/%h exp=0/0", rdat3, sa3);
        end
        rd3 = 1'b0;
        #1;
        n_vec++; if ({rdy3, we3, oe3} !== 3'b110) begin
            n_err++; $display("FAIL rst_idle got rdy/we_n/oe=%b/%b/%b exp=1/1/0", rdy3, we3, oe3);
        end
        @(negedge clk);
        rst3 = 1'b1;

        @(negedge clk);
        rd3 = 1'b1; a3 = 32'd1040;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            n_vec++;
            if (rdy3 !== (c == 7)) begin n_err++; $display("FAIL reread_ready cyc=%0d got=%b exp=%b", c, rdy3, (c == 7)); end
        end
        n_vec++; if (rdat3 !== 32'h12345678) begin n_err++; $display("FAIL reread_word got=%h exp=%h", rdat3, 32'h12345678); end
        rd3 = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_wrap;
        logic        er  [0:2];
        logic [17:0] ea  [0:2];
        logic [15:0] edq [0:2];
        er  = '{1'b0, 1'b0, 1'b1};
        ea  = '{18'h3FFFE, 18'h3FFFF, 18'h3FFFE};
        edq = '{16'hF00D, 16'hCAFE, 16'h0000};

        @(negedge clk);
        wr1 = 1'b1; a1 = 32'd1020; wd1 = 32'hCAFEF00D;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_vec++;
            if ({rdy1, we1, sa1} !== {er[c-1], er[c-1], ea[c-1]}) begin
                n_err++;
                $display("FAIL wrap_wr cyc=%0d got rdy/we_n/addr=%b/%b/%h exp=%b/%b/%h",
                         c, rdy1, we1, sa1, er[c-1], er[c-1], ea[c-1]);
            end
            if (c <= 2) begin
                n_vec++;
                if (dqo1 !== edq[c-1]) begin n_err++; $display("FAIL wrap_dq cyc=%0d got=%h exp=%h", c, dqo1, edq[c-1]); end
            end
        end
        wr1 = 1'b0;

        @(negedge clk);
        rd1 = 1'b1; a1 = 32'd1020;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_vec++;
            if ({rdy1, sa1} !== {er[c-1], ea[c-1]}) begin
                n_err++;
                $display("FAIL wrap_rd cyc=%0d got rdy/addr=%b/%h exp=%b/%h", c, rdy1, sa1, er[c-1], ea[c-1]);
            end
        end
        n_vec++; if (rdat1 !== 32'hCAFEF00D) begin n_err++; $display("FAIL wrap_word got=%h exp=%h", rdat1, 32'hCAFEF00D); end
        rd1 = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    initial begin
        test_reset();
        test_write_then_read();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_rd_hi();
        test_wrap();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
